// File: rtl/csum_pkg.sv
// Shared definitions for the Internet (ones' complement) checksum blocks.
//   CSUM_W     : checksum width in bits
//   CSUM_GOOD  : folded sum of a packet whose embedded checksum is correct
//   LANE_SUM_W : width of the per-beat masked lane sum (four 16-bit lanes)
//   ACC_W      : width of the on-the-fly folded packet accumulator
//   fold16     : adds the upper 16 bits of a 32-bit value into the low 16 bits
package csum_pkg;

  localparam int unsigned CSUM_W     = 16;
  localparam logic [CSUM_W-1:0] CSUM_GOOD = 16'hFFFF;
  localparam int unsigned LANE_SUM_W = 18;
  // acc[15:0] + acc[18:16] + lane_sum never exceeds 19 bits, so no length limit.
  localparam int unsigned ACC_W      = 19;

  function automatic logic [CSUM_W:0] fold16(input logic [31:0] v);
    return {1'b0, v[15:0]} + {1'b0, v[31:16]};
  endfunction

endpackage

// File: rtl/csum_lane_adder.sv
// Combinational masked lane adder for one beat.
// Every byte with keep=0 is replaced by 8'h00, then the 16-bit lanes are summed.
// Ports:
//   data     : beat data, network byte order (data[63:56] first on the wire)
//   keep     : byte enables, keep[i] qualifies data[8*i+7:8*i]
//   lane_sum : sum of the masked 16-bit lanes
module csum_lane_adder
  import csum_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned KEEP_W = DATA_W / 8
) (
  input  logic [DATA_W-1:0]     data,
  input  logic [KEEP_W-1:0]     keep,
  output logic [LANE_SUM_W-1:0] lane_sum
);

  localparam int unsigned Lanes = DATA_W / 16;

  logic [DATA_W-1:0] masked;

  always_comb begin
    masked = '0;
    for (int b = 0; b < KEEP_W; b++) begin
      masked[8*b +: 8] = data[8*b +: 8] & {8{keep[b]}};
    end
  end

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < Lanes; i++) begin
      lane_sum = lane_sum + LANE_SUM_W'(masked[16*i +: 16]);
    end
  end

endmodule

// File: rtl/checksum_verifier.sv
// Receive-side Internet checksum verifier.
// Streams a packet in DATA_W-bit beats, sums all kept bytes (including the
// embedded checksum field) in ones' complement and reports a verdict per
// packet: ok when the folded sum equals 16'hFFFF. Always ready, fixed
// 4-cycle latency from the last beat to chk_valid, one result per cycle.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   s_valid   : beat qualifier, consumed on every rising edge where high
//   s_data    : beat data, s_data[63:48] is the first 16-bit word
//   s_keep    : byte enables, s_keep[7] qualifies s_data[63:56]
//   s_last    : final beat of the packet
//   chk_valid : one-cycle pulse per completed packet
//   chk_ok    : folded sum == 16'hFFFF (valid with chk_valid, held otherwise)
//   chk_sum   : folded ones' complement sum (held between packets)
//   pkt_cnt   : completed packets, wraps
//   err_cnt   : failed packets, saturates at all-ones
module checksum_verifier
  import csum_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned KEEP_W = DATA_W / 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic [KEEP_W-1:0] s_keep,
  input  logic              s_last,
  output logic              chk_valid,
  output logic              chk_ok,
  output logic [CSUM_W-1:0] chk_sum,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  logic [LANE_SUM_W-1:0] lane_sum_c;
  logic [LANE_SUM_W-1:0] lane_sum;
  logic                  v_d;
  logic                  last_d;
  logic [ACC_W-1:0]      acc;
  logic [ACC_W-1:0]      nxt;
  logic [ACC_W-1:0]      fin;
  logic                  fin_v;
  logic [CSUM_W:0]       f1;
  logic                  f1_v;
  logic [CSUM_W-1:0]     sum_c;

  csum_lane_adder #(
    .DATA_W (DATA_W),
    .KEEP_W (KEEP_W)
  ) u_lane_adder (
    .data     (s_data),
    .keep     (s_keep),
    .lane_sum (lane_sum_c)
  );

  // Fold the accumulator's carries back in on every beat so it stays bounded.
  always_comb begin
    nxt = ACC_W'(acc[15:0]) + ACC_W'(acc[ACC_W-1:16]) + ACC_W'(lane_sum);
  end

  // f1 is at most 17'h10006, so one more end-around carry cannot overflow.
  always_comb begin
    sum_c = f1[CSUM_W-1:0] + CSUM_W'(f1[CSUM_W]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_sum  <= '0;
      v_d       <= 1'b0;
      last_d    <= 1'b0;
      acc       <= '0;
      fin       <= '0;
      fin_v     <= 1'b0;
      f1        <= '0;
      f1_v      <= 1'b0;
      chk_valid <= 1'b0;
      chk_ok    <= 1'b0;
      chk_sum   <= '0;
      pkt_cnt   <= '0;
      err_cnt   <= '0;
    end else begin
      // Stage 1: masked lane sum of the sampled beat.
      lane_sum <= lane_sum_c;
      v_d      <= s_valid;
      last_d   <= s_valid & s_last;

      // Stage 2: accumulate; on the last beat hand off and clear so the next
      // packet can start on the following beat. Idle gaps leave acc alone.
      fin_v <= v_d & last_d;
      if (v_d) begin
        if (last_d) begin
          fin <= nxt;
          acc <= '0;
        end else begin
          acc <= nxt;
        end
      end

      // Stage 3: first fold of the final sum.
      f1   <= fold16(32'(fin));
      f1_v <= fin_v;

      // Stage 4: final fold, verdict and statistics.
      chk_valid <= f1_v;
      if (f1_v) begin
        chk_sum <= sum_c;
        chk_ok  <= (sum_c == CSUM_GOOD);
        pkt_cnt <= pkt_cnt + CNT_W'(1);
        if ((sum_c != CSUM_GOOD) && (err_cnt != '1)) begin
          err_cnt <= err_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_checksum_verifier.sv
// Directed self-checking bench for checksum_verifier.
module tb_checksum_verifier;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic [63:0] s_data;
  logic [7:0]  s_keep;
  logic        s_last;
  logic        chk_valid;
  logic        chk_ok;
  logic [15:0] chk_sum;
  logic [15:0] pkt_cnt;
  logic [15:0] err_cnt;

  int checks = 0;
  int errors = 0;

  // Results captured as {ok, sum} on each chk_valid pulse.
  logic [16:0] got_q[$];

  checksum_verifier #(
    .DATA_W (64),
    .KEEP_W (8),
    .CNT_W  (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_keep    (s_keep),
    .s_last    (s_last),
    .chk_valid (chk_valid),
    .chk_ok    (chk_ok),
    .chk_sum   (chk_sum),
    .pkt_cnt   (pkt_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (chk_valid === 1'b1) got_q.push_back({chk_ok, chk_sum});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l);
    s_valid = 1'b1;
    s_data  = d;
    s_keep  = k;
    s_last  = l;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    s_keep  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    got_q.delete();
  endtask

  // Pop the next captured result and compare against the expected one.
  task automatic expect_res(input string tag, input logic [15:0] sum, input logic ok);
    logic [16:0] r;
    if (got_q.size() > 0) r = got_q.pop_front();
    else r = ~{ok, sum};
    check({tag, " sum"}, 32'(r[15:0]), 32'(sum));
    check({tag, " ok"}, 32'(r[16]), 32'(ok));
  endtask

  task automatic send_hdr(input logic [15:0] csum_word);
    send(64'h4500007300004000, 8'hFF, 1'b0);
    send({32'h4011_0000 | 32'(csum_word), 32'hC0A80001}, 8'hFF, 1'b0);
    send(64'hC0A800C7DEADBEEF, 8'hF0, 1'b1);
  endtask

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_keep  = '0;
    s_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst chk_valid", 32'(chk_valid), 32'd0);
    check("rst chk_ok", 32'(chk_ok), 32'd0);
    check("rst chk_sum", 32'(chk_sum), 32'h0);
    check("rst pkt_cnt", 32'(pkt_cnt), 32'h0);
    check("rst err_cnt", 32'(err_cnt), 32'h0);
    rst = 1'b0;
    got_q.delete();

    // Good IPv4 header with exact latency check.
    send_hdr(16'hB861);
    idle(1);
    check("lat k+1 valid", 32'(chk_valid), 32'd0);
    idle(1);
    check("lat k+2 valid", 32'(chk_valid), 32'd0);
    idle(1);
    check("lat k+3 valid", 32'(chk_valid), 32'd1);
    check("s1 sum", 32'(chk_sum), 32'hFFFF);
    check("s1 ok", 32'(chk_ok), 32'd1);
    check("s1 pkt_cnt", 32'(pkt_cnt), 32'd1);
    check("s1 err_cnt", 32'(err_cnt), 32'd0);
    idle(1);
    check("pulse width", 32'(chk_valid), 32'd0);
    check("hold sum", 32'(chk_sum), 32'hFFFF);
    got_q.delete();

    // Corrupted checksum field.
    send_hdr(16'hB862);
    idle(5);
    check("s2 pulses", got_q.size(), 1);
    expect_res("s2", 16'h0001, 1'b0);
    check("s2 err_cnt", 32'(err_cnt), 32'd1);
    check("s2 pkt_cnt", 32'(pkt_cnt), 32'd2);

    // Masked garbage and odd-length tail.
    send(64'hFFFF123456789ABC, 8'hC0, 1'b1);
    send(64'hAB11000000000000, 8'h80, 1'b1);
    idle(5);
    check("mask pulses", got_q.size(), 2);
    expect_res("mask C0", 16'hFFFF, 1'b1);
    expect_res("odd 80", 16'hAB00, 1'b0);
    check("mask pkt_cnt", 32'(pkt_cnt), 32'd4);
    check("mask err_cnt", 32'(err_cnt), 32'd2);

    // Carry stress with an idle gap inside the packet.
    send(64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b0);
    idle(3);
    send(64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b0);
    send(64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b1);
    idle(6);
    check("carry pulses", got_q.size(), 1);
    expect_res("carry", 16'hFFFF, 1'b1);
    check("carry pkt_cnt", 32'(pkt_cnt), 32'd5);

    // Back-to-back packets, no gaps.
    do_reset();
    send_hdr(16'hB861);
    send_hdr(16'hB862);
    send(64'hFFFF123456789ABC, 8'hC0, 1'b1);
    send(64'hAB11000000000000, 8'h80, 1'b1);
    send(64'hDEADBEEFCAFEF00D, 8'h00, 1'b1);
    send(64'h123456789ABCDEF0, 8'hA5, 1'b1);
    idle(6);
    check("b2b pulses", got_q.size(), 6);
    expect_res("b2b p1", 16'hFFFF, 1'b1);
    expect_res("b2b p2", 16'h0001, 1'b0);
    expect_res("b2b p3", 16'hFFFF, 1'b1);
    expect_res("b2b p4", 16'hAB00, 1'b0);
    expect_res("b2b zero", 16'h0000, 1'b0);
    expect_res("b2b sparse", 16'h69AC, 1'b0);
    check("b2b pkt_cnt", 32'(pkt_cnt), 32'd6);
    check("b2b err_cnt", 32'(err_cnt), 32'd4);

    // Reset in the middle of a packet, then replay it.
    do_reset();
    send(64'h4500007300004000, 8'hFF, 1'b0);
    send(64'h4011B861C0A80001, 8'hFF, 1'b0);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(6);
    check("partial pulses", got_q.size(), 0);
    send_hdr(16'hB861);
    idle(6);
    check("replay pulses", got_q.size(), 1);
    expect_res("replay", 16'hFFFF, 1'b1);
    check("replay pkt_cnt", 32'(pkt_cnt), 32'd1);
    check("replay err_cnt", 32'(err_cnt), 32'd0);

    // Drive err_cnt to all-ones, then one more bad packet.
    got_q.delete();
    repeat (65535) send(64'hAB11000000000000, 8'h80, 1'b1);
    idle(6);
    check("bulk pulses", got_q.size(), 65535);
    check("bulk err_cnt", 32'(err_cnt), 32'hFFFF);
    check("pkt_cnt wrap", 32'(pkt_cnt), 32'h0);
    got_q.delete();
    send(64'hAB11000000000000, 8'h80, 1'b1);
    idle(6);
    check("sat pulses", got_q.size(), 1);
    expect_res("sat", 16'hAB00, 1'b0);
    check("sat err_cnt", 32'(err_cnt), 32'hFFFF);
    check("sat pkt_cnt", 32'(pkt_cnt), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/checksum_verifier.md
Name: checksum_verifier

Overview:
- Receive-side counterpart of the checksum generator: streams a packet in 64-bit beats and computes the 16-bit ones' complement (Internet) sum over all valid bytes, including the embedded checksum field.
- Reports a pass/fail verdict per packet. The packet passes when the folded sum equals 16'hFFFF.
- Sits after the MAC/packet-parser RX path. Feeds the drop/accept decision for IPv4/UDP/TCP headers or payloads.
- Always ready: there is no backpressure.

Parameters:
- DATA_W, 64, beat width in bits. Must be a multiple of 16. Only 64 is verified.
- KEEP_W, DATA_W/8, byte-enable width.
- CNT_W, 16, width of the packet and error statistics counters.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- s_valid  input  1  beat qualifier. A beat is consumed on every rising edge where s_valid=1.
- s_data  input  DATA_W  beat data, network byte order. s_data[63:56] is the first byte on the wire; s_data[63:48] is the first 16-bit word.
- s_keep  input  KEEP_W  byte enables. s_keep[7] qualifies s_data[63:56].
- s_last  input  1  final beat of the packet.
- chk_valid  output  1  one-cycle pulse per completed packet.
- chk_ok  output  1  1 when the folded sum is 16'hFFFF. Meaningful only while chk_valid=1.
- chk_sum  output  16  folded ones' complement sum of the packet.
- pkt_cnt  output  CNT_W  count of completed packets. Wraps.
- err_cnt  output  CNT_W  count of packets with chk_ok=0. Saturates at all-ones.

Behaviour:
- Reset (async assert, sampled deassert): all pipeline registers and the accumulator clear to 0. chk_valid=0, chk_ok=0, chk_sum=0, pkt_cnt=0, err_cnt=0.
- Reset during a packet discards the partial packet. The first beat after reset starts a new packet.
- Byte masking: any byte with keep=0 contributes 8'h00, regardless of its data value. This handles odd-length tails, since the high byte is kept and the low byte is zero-padded. Non-contiguous keep is legal and is masked bytewise.
- Stage 1 (edge k, beat sampled):
  - lane_sum <= sum of the four masked 16-bit lanes (18 bits).
  - last_d <= s_valid & s_last.
  - v_d <= s_valid.
- Stage 2 (edge k+1), when v_d=1:
  - nxt = acc[15:0] + acc[31:16] + lane_sum. This folds on the fly; the result is at most 19 bits, so there is no packet length limit.
  - If last_d=0: acc <= nxt.
  - If last_d=1: fin <= nxt, fin_v <= 1, and acc <= 0. The next packet may start on the very next beat.
  - When v_d=0, acc holds. Idle gaps inside a packet are allowed.
- Stage 3 (edge k+2): f1 <= fin[15:0] + fin[31:16] (17 bits), f1_v <= fin_v.
- Stage 4 (edge k+3):
  - chk_sum <= f1[15:0] + f1[16].
  - chk_ok <= (that value == 16'hFFFF).
  - chk_valid <= f1_v.
  - pkt_cnt increments; err_cnt increments (saturating) when the result fails.
- Latency: a last beat sampled at edge k gives chk_valid high during the cycle after edge k+3. Fixed at 4 cycles.
- Throughput: one result per cycle. Back-to-back single-beat packets each produce their own pulse.
- A packet whose masked data is all zero gives chk_sum=0000 and chk_ok=0. This is the required behaviour; there is no special case for it.
- chk_ok and chk_sum hold their last values when chk_valid=0.

Decomposition:
- Shared package csum_pkg:
  - CSUM_W=16 and CSUM_GOOD=16'hFFFF.
  - A fold16 function (add the upper bits into the low 16 bits). The generator also uses this function.
- One sub-module: csum_lane_adder, combinational. It takes data and keep and returns the 18-bit masked lane sum. It is reused by the generator when that block gets a real implementation.

Test Plan:
- IPv4 header, 3 beats: 64'h4500007300004000 (keep FF), 64'h4011B861C0A80001 (keep FF), 64'hC0A800C7DEADBEEF (keep F0, last) -> chk_valid 4 cycles after the last beat, chk_sum=FFFF, chk_ok=1, pkt_cnt=1, err_cnt=0.
- Same header with B861 replaced by B862 -> chk_sum=0001, chk_ok=0, err_cnt=1.
- Masked garbage / odd length: single beat 64'hFFFF123456789ABC with keep C0 and last -> chk_sum=FFFF, ok=1. Single beat 64'hAB11000000000000 with keep 80 and last -> chk_sum=AB00, ok=0.
- Carry stress: 3 beats of 64'hFFFFFFFFFFFFFFFF (keep FF) with an idle gap between beats 1 and 2 -> chk_sum=FFFF, ok=1, exactly one chk_valid pulse.
- Back-to-back: packets from scenarios 1 and 2 with no gap, then 4 consecutive single-beat packets -> 6 pulses, in order, with correct per-packet results. pkt_cnt=6.
- Reset mid-packet: rst asserted after beat 2 of scenario 1, then scenario 1 replayed in full -> no pulse for the partial packet. Replay gives chk_ok=1 and pkt_cnt=1. Also force err_cnt to all-ones and send one more bad packet -> err_cnt stays at all-ones.
